// File: rtl/gcd_stein.sv
// Binary (Stein) GCD with val/rdy operand and result handshakes.
// Optional CALC cycle-count output, enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_stein #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] operands_bits_A,
  input  logic [W-1:0] operands_bits_B,
  input  logic         operands_val,
  output logic         operands_rdy,
  output logic [W-1:0] result_bits_data,
  output logic         result_val,
  input  logic         result_rdy,
  output logic         busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [$clog2(4*W+2)-1:0] result_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for operands, operands_rdy high
  // CALC  | one Stein reduction step per cycle
  // DONE  | result valid, waiting for result_rdy
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int KW = $clog2(W+1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   res_q, res_d;

`ifdef GCD_CYCLE_COUNT_EN
  localparam int CW = $clog2(4*W+2);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  rcyc_q, rcyc_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= '0;
      rcyc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= cnt_d;
      rcyc_q  <= rcyc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    res_d   = res_q;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_d   = cnt_q;
    rcyc_d  = rcyc_q;
`endif
    case (state_q)
      IDLE: begin
        if (operands_val) begin
          a_d     = operands_bits_A;
          b_d     = operands_bits_B;
          k_d     = '0;
          state_d = CALC;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      CALC: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (b_q == '0) begin
          res_d   = a_q << k_q;
          state_d = DONE;
`ifdef GCD_CYCLE_COUNT_EN
          rcyc_d  = cnt_q + CW'(1);
`endif
        end else if (a_q == '0) begin
          res_d   = b_q << k_q;
          state_d = DONE;
`ifdef GCD_CYCLE_COUNT_EN
          rcyc_d  = cnt_q + CW'(1);
`endif
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q < b_q) begin
          // both odd: keep the smaller, replace the other with the (even) difference
          b_d = b_q - a_q;
        end else begin
          a_d = b_q;
          b_d = a_q - b_q;
        end
      end
      DONE: begin
        if (result_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign operands_rdy     = (state_q == IDLE);
  assign busy             = (state_q == CALC);
  assign result_val       = (state_q == DONE);
  assign result_bits_data = res_q;
`ifdef GCD_CYCLE_COUNT_EN
  assign result_cycles    = rcyc_q;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Scoreboard bench for gcd_stein (W=16); checks result_cycles when GCD_CYCLE_COUNT_EN is defined.
module tb_gcd_stein;
  localparam int W    = 16;
  localparam int MAXC = 4*W+1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] operands_bits_A = '0;
  logic [W-1:0] operands_bits_B = '0;
  logic         operands_val = 1'b0;
  logic         operands_rdy;
  logic [W-1:0] result_bits_data;
  logic         result_val;
  logic         result_rdy = 1'b0;
  logic         busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [$clog2(4*W+2)-1:0] result_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  gcd_stein #(.W(W)) dut (
    .clk(clk),
    .reset(reset),
    .operands_bits_A(operands_bits_A),
    .operands_bits_B(operands_bits_B),
    .operands_val(operands_val),
    .operands_rdy(operands_rdy),
    .result_bits_data(result_bits_data),
    .result_val(result_val),
    .result_rdy(result_rdy),
    .busy(busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .result_cycles(result_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic do_reset();
    #3 reset = 1'b0;
    operands_val = 1'b0;
    result_rdy   = 1'b0;
    exp_q.delete();
    #10 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // exp_cyc < 0 means the exact CALC length is not checked, only the bound
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                     input bit pre_rdy, input bit noise, input int exp_cyc);
    int n;
    bit rdy_seen, unstable;
    logic [W-1:0] e, d0;
    n = 0;
    while (!operands_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!operands_rdy) chk("rdy_wait", operands_rdy, 1);
    operands_bits_A = a;
    operands_bits_B = b;
    operands_val    = 1'b1;
    exp_q.push_back(ref_gcd(a, b));
    @(posedge clk); #1;
    operands_val = 1'b0;
    result_rdy   = pre_rdy;
    n = 0;
    rdy_seen = 0;
    while (!result_val && n <= MAXC + 2) begin
      if (operands_rdy || !busy) rdy_seen = 1;
      if (noise) begin
        operands_val    = 1'($urandom);
        operands_bits_A = W'($urandom);
        operands_bits_B = W'($urandom);
      end
      n++;
      @(posedge clk); #1;
    end
    operands_val = 1'b0;
    chk("result_val", result_val, 1);
    if (!result_val) begin
      do_reset();
      return;
    end
    chk("calc_rdy_low", rdy_seen, 0);
    chk("bound", n <= MAXC, 1);
    if (exp_cyc >= 0) chk("calc_cycles", n, exp_cyc);
`ifdef GCD_CYCLE_COUNT_EN
    chk("result_cycles", result_cycles, n);
`endif
    e = exp_q.pop_front();
    chk("data", result_bits_data, e);
    if (!pre_rdy) begin
      d0 = result_bits_data;
      unstable = 0;
      repeat (hold) begin
        if (noise) begin
          operands_val    = 1'($urandom);
          operands_bits_A = W'($urandom);
        end
        @(posedge clk); #1;
        if (result_val !== 1'b1 || result_bits_data !== d0 || operands_rdy || busy) unstable = 1;
      end
      operands_val = 1'b0;
      if (hold > 0) chk("hold_stable", unstable, 0);
      result_rdy = 1'b1;
    end
    @(posedge clk); #1;
    result_rdy = 1'b0;
    chk("done_exit", {result_val, operands_rdy, busy}, 3'b010);
    chk("data_kept", result_bits_data, e);
  endtask

  initial begin
    #12;
    chk("rst_val", result_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", result_bits_data, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", operands_rdy, 1);

    txn(16'd12, 16'd18, 0, 0, 0, 6);
    txn(16'd0, 16'd0, 0, 0, 0, 1);
    txn(16'd0, 16'd7, 0, 0, 0, -1);
    txn(16'd9, 16'd0, 0, 0, 0, -1);
    txn(16'hFFFF, 16'hFFFF, 0, 0, 0, 2);
    txn(16'h8000, 16'h4000, 0, 0, 0, -1);
    txn(16'hFFFF, 16'd1, 0, 0, 0, -1);
    txn(16'd48, 16'd180, 10, 0, 1, -1);
    txn(16'd1000, 16'd250, 0, 1, 0, -1);

    // asynchronous reset in the middle of a computation
    operands_bits_A = 16'hFFFF;
    operands_bits_B = 16'd1;
    operands_val    = 1'b1;
    @(posedge clk); #1;
    operands_val = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("busy_before_rst", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_val", result_val, 0);
    chk("abort_data", result_bits_data, 0);
    #6 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", operands_rdy, 1);
    txn(16'd35, 16'd21, 0, 0, 0, -1);

    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 3))
        0: begin a = W'($urandom); b = W'($urandom); end
        1: begin a = ($urandom_range(0, 1) != 0) ? W'(0) : W'($urandom); b = (a != 0) ? W'(0) : W'($urandom); end
        2: begin a = W'(1) << $urandom_range(0, W-1); b = W'(1) << $urandom_range(0, W-1); end
        default: begin a = W'($urandom_range(0, 63)); b = W'($urandom_range(0, 63)); end
      endcase
      txn(a, b, $urandom_range(0, 2), 1'($urandom), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
